// File: rtl/time_counter.sv
// 24-hour BCD time-of-day counter (00:00..23:59) with minute increment,
// validated parallel load, and registered day-wrap / load-error pulses.
module time_counter (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_minute,
   input  logic       load_new_c,
   input  logic [3:0] new_current_time_ms_hr,
   input  logic [3:0] new_current_time_ls_hr,
   input  logic [3:0] new_current_time_ms_min,
   input  logic [3:0] new_current_time_ls_min,
   output logic [3:0] current_time_ms_hr,
   output logic [3:0] current_time_ls_hr,
   output logic [3:0] current_time_ms_min,
   output logic [3:0] current_time_ls_min,
   output logic       day_wrap,
   output logic       load_error
);

   typedef struct packed {
      logic [3:0] ms_hr;
      logic [3:0] ls_hr;
      logic [3:0] ms_min;
      logic [3:0] ls_min;
   } bcd_time_t;

   bcd_time_t time_q, time_d, time_inc, time_new;
   logic      day_wrap_q, day_wrap_d;
   logic      load_error_q, load_error_d;
   logic      load_valid;
   logic      at_end_of_day;

   assign time_new = '{ms_hr:  new_current_time_ms_hr,
                       ls_hr:  new_current_time_ls_hr,
                       ms_min: new_current_time_ms_min,
                       ls_min: new_current_time_ls_min};

   always_comb begin
      load_valid = (time_new.ms_hr  <= 4'd2) &&
                   (time_new.ls_hr  <= 4'd9) &&
                   (time_new.ms_min <= 4'd5) &&
                   (time_new.ls_min <= 4'd9) &&
                   !((time_new.ms_hr == 4'd2) && (time_new.ls_hr > 4'd3));
   end

   // Ripple carry through the four digits; the hour pair wraps at 23.
   always_comb begin
      time_inc      = time_q;
      at_end_of_day = 1'b0;
      if (time_q.ls_min != 4'd9) begin
         time_inc.ls_min = time_q.ls_min + 4'd1;
      end else begin
         time_inc.ls_min = 4'd0;
         if (time_q.ms_min != 4'd5) begin
            time_inc.ms_min = time_q.ms_min + 4'd1;
         end else begin
            time_inc.ms_min = 4'd0;
            if ((time_q.ms_hr == 4'd2) && (time_q.ls_hr == 4'd3)) begin
               time_inc.ms_hr = 4'd0;
               time_inc.ls_hr = 4'd0;
               at_end_of_day  = 1'b1;
            end else if (time_q.ls_hr == 4'd9) begin
               time_inc.ls_hr = 4'd0;
               time_inc.ms_hr = time_q.ms_hr + 4'd1;
            end else begin
               time_inc.ls_hr = time_q.ls_hr + 4'd1;
            end
         end
      end
   end

   // Load wins over the minute strobe, even when the load is rejected.
   always_comb begin
      time_d       = time_q;
      day_wrap_d   = 1'b0;
      load_error_d = 1'b0;
      if (load_new_c) begin
         if (load_valid) time_d       = time_new;
         else            load_error_d = 1'b1;
      end else if (one_minute) begin
         time_d     = time_inc;
         day_wrap_d = at_end_of_day;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         time_q       <= '0;
         day_wrap_q   <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         time_q       <= time_d;
         day_wrap_q   <= day_wrap_d;
         load_error_q <= load_error_d;
      end
   end

   assign current_time_ms_hr  = time_q.ms_hr;
   assign current_time_ls_hr  = time_q.ls_hr;
   assign current_time_ms_min = time_q.ms_min;
   assign current_time_ls_min = time_q.ls_min;
   assign day_wrap            = day_wrap_q;
   assign load_error          = load_error_q;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: directed scenarios plus randomized traffic, checked
// against a minutes-of-day reference model.
module tb_time_counter;

   logic       clock = 1'b0;
   logic       reset;
   logic       one_minute, load_new_c;
   logic [3:0] n_mh, n_lh, n_mm, n_lm;
   logic [3:0] c_mh, c_lh, c_mm, c_lm;
   logic       day_wrap, load_error;

   int total = 0;
   int bad   = 0;

   // reference state: minutes since midnight, plus expected pulses
   int m_time;
   bit m_wrap, m_err;

   time_counter dut (
      .clock                  (clock),
      .reset                  (reset),
      .one_minute             (one_minute),
      .load_new_c             (load_new_c),
      .new_current_time_ms_hr (n_mh),
      .new_current_time_ls_hr (n_lh),
      .new_current_time_ms_min(n_mm),
      .new_current_time_ls_min(n_lm),
      .current_time_ms_hr     (c_mh),
      .current_time_ls_hr     (c_lh),
      .current_time_ms_min    (c_mm),
      .current_time_ls_min    (c_lm),
      .day_wrap               (day_wrap),
      .load_error             (load_error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int t);
      int h, m;
      h = t / 60;
      m = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   function automatic bit legal(input logic [15:0] d);
      int h, m;
      if (d[15:12] > 9 || d[11:8] > 9 || d[7:4] > 9 || d[3:0] > 9) return 1'b0;
      h = d[15:12] * 10 + d[11:8];
      m = d[7:4] * 10 + d[3:0];
      return (h < 24) && (m < 60);
   endfunction

   function automatic int to_min(input logic [15:0] d);
      return (d[15:12] * 10 + d[11:8]) * 60 + d[7:4] * 10 + d[3:0];
   endfunction

   function automatic logic [15:0] shown();
      return {c_mh, c_lh, c_mm, c_lm};
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".time"}, shown(), to_bcd(m_time));
      chk({tag, ".wrap"}, day_wrap, m_wrap);
      chk({tag, ".err"}, load_error, m_err);
   endtask

   // one cycle: drive away from the edge, update model on the edge, sample after
   task automatic step(input bit om, input bit ld, input logic [15:0] d, input string tag);
      @(negedge clock);
      one_minute = om;
      load_new_c = ld;
      {n_mh, n_lh, n_mm, n_lm} = d;
      @(posedge clock);
      m_wrap = 1'b0;
      m_err  = 1'b0;
      if (ld) begin
         if (legal(d)) m_time = to_min(d);
         else          m_err  = 1'b1;
      end else if (om) begin
         m_wrap = (m_time == 1439);
         m_time = (m_time + 1) % 1440;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [15:0] d;
      reset = 1'b1;
      one_minute = 1'b1;
      load_new_c = 1'b0;
      {n_mh, n_lh, n_mm, n_lm} = 16'h1234;
      m_time = 0; m_wrap = 0; m_err = 0;
      #2;
      check_all("rst_async");
      // strobes and loads are ignored while reset is held
      @(posedge clock); #1;
      load_new_c = 1'b1;
      @(posedge clock); #1;
      check_all("rst_hold");
      @(negedge clock);
      reset = 1'b0;
      one_minute = 1'b0;
      load_new_c = 1'b0;

      // ten minute strobes from reset
      for (int i = 0; i < 10; i++) step(1, 0, 16'h0, "inc10");
      chk("inc10.final", shown(), 16'h0010);

      step(0, 1, 16'h1259, "ld1259");
      step(1, 0, 16'h0, "to1300");
      chk("to1300.final", shown(), 16'h1300);

      step(0, 1, 16'h2359, "ld2359");
      step(1, 0, 16'h0, "wrap");
      chk("wrap.pulse", day_wrap, 1);
      step(0, 0, 16'h0, "wrap_end");
      chk("wrap_end.pulse", day_wrap, 0);

      step(0, 1, 16'h2359, "ld2359b");
      step(0, 1, 16'h0000, "ld0000");
      chk("ld_no_wrap", day_wrap, 0);

      step(0, 1, 16'h0715, "ld0715");
      step(0, 1, 16'h2400, "bad2400");
      step(0, 1, 16'h1960, "bad1960");
      step(0, 1, 16'h1A00, "bad1A00");
      chk("bad.hold", shown(), 16'h0715);
      step(1, 1, 16'h2400, "bad_with_min");
      chk("bad_with_min.hold", shown(), 16'h0715);

      step(0, 1, 16'h0505, "ld0505");
      step(1, 1, 16'h0830, "ld_prio");
      chk("ld_prio.final", shown(), 16'h0830);

      for (int i = 0; i < 4; i++) step(0, 0, 16'h0, "idle");

      // asynchronous reset between edges aborts a pending strobe and bad load
      step(0, 1, 16'h1742, "ld1742");
      @(negedge clock);
      one_minute = 1'b1;
      load_new_c = 1'b1;
      {n_mh, n_lh, n_mm, n_lm} = 16'h2A99;
      #2;
      reset = 1'b1;
      m_time = 0; m_wrap = 0; m_err = 0;
      #1;
      check_all("mid_rst");
      @(posedge clock); #1;
      check_all("mid_rst_edge");
      @(negedge clock);
      reset = 1'b0;
      one_minute = 1'b0;
      load_new_c = 1'b0;
      step(1, 0, 16'h0, "post_rst");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 40)      d = to_bcd($urandom_range(0, 1439));
         else if (r < 70) d = to_bcd($urandom_range(1435, 1439));
         else             d = 16'($urandom);
         step(bit'($urandom_range(0, 1)), ($urandom_range(0, 99) < 8), d, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d", total);
      $fatal(1);
   end

endmodule
